// File: rtl/packet_frame_arbiter_pkg.sv
// Shared definitions for the framed-packet round-robin arbiter.
// Holds the FSM state encoding and the round-robin winner select.
package pkt_arb_pkg;

    localparam int MAXREQ = 8;
    localparam int PTR_W  = 3;
    localparam int IDX_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_PACKET  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // First set request at or after ptr, wrapping within the n live requesters.
    function automatic logic [MAXREQ-1:0] onehot_rr(input logic [MAXREQ-1:0] req,
                                                    input logic [PTR_W-1:0]  ptr,
                                                    input int                n);
        logic [MAXREQ-1:0] win;
        logic              found;
        logic [IDX_W-1:0]  idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAXREQ; i++) begin
            idx = {1'b0, ptr} + IDX_W'(i);
            if (idx >= IDX_W'(n))
                idx = idx - IDX_W'(n);
            if ((i < n) && !found && req[idx[PTR_W-1:0]]) begin
                win[idx[PTR_W-1:0]] = 1'b1;
                found               = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/packet_frame_arbiter_rr_pick.sv
// Combinational round-robin priority select over NREQ requesters.
module rr_pick
    import pkt_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick
);

    logic [MAXREQ-1:0] win_ext;

    assign win_ext = onehot_rr(MAXREQ'(req), PTR_W'(ptr), NREQ);
    assign pick    = win_ext[NREQ-1:0];

    generate
        if (NREQ < MAXREQ) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^win_ext[MAXREQ-1:NREQ];
        end
    endgenerate

endmodule

// File: rtl/packet_frame_arbiter.sv
// Round-robin arbiter sharing one head/tail/valid packet channel among NREQ
// requesters; a grant is held from head to tail and all outputs are registered.
module packet_frame_arbiter
    import pkt_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] in_valid,
    input  logic [NREQ-1:0] in_head,
    input  logic [NREQ-1:0] in_tail,
    output logic [NREQ-1:0] grant,
    output logic            out_valid,
    output logic            out_head,
    output logic            out_tail,
    output logic            busy,
    output logic            err
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [NREQ-1:0] pick, grant_nxt;
    logic [PW-1:0]   rr_ptr, ptr_nxt, win_idx, win_nxt, pick_idx;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            err_nxt;
    logic            wv, wh, wt;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req  (req),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i])
                pick_idx = PW'(i);
    end

    // Only the granted requester's beat is visible; grant==0 forces all zero.
    assign wv = |(in_valid & grant);
    assign wh = |(in_valid & in_head & grant);
    assign wt = |(in_valid & in_tail & grant);

    assign busy = (state == ST_GRANTED) || (state == ST_PACKET);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = rr_ptr;
        win_nxt   = win_idx;
        cnt_nxt   = cnt;
        err_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt = pick;
                    win_nxt   = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                if (wv) begin
                    if (wh)
                        state_nxt = wt ? ST_RELEASE : ST_PACKET;
                    else
                        err_nxt = 1'b1;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = ST_RELEASE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ST_PACKET: begin
                // A stalled packet keeps the channel: no timeout here.
                if (wh)
                    err_nxt = 1'b1;
                if (wt)
                    state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                grant_nxt = '0;
                ptr_nxt   = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Registered control and output stage
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant     <= '0;
            rr_ptr    <= '0;
            win_idx   <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_head  <= 1'b0;
            out_tail  <= 1'b0;
        end else begin
            grant     <= grant_nxt;
            rr_ptr    <= ptr_nxt;
            win_idx   <= win_nxt;
            cnt       <= cnt_nxt;
            err       <= err_nxt;
            out_valid <= wv;
            out_head  <= wh;
            out_tail  <= wt;
        end
    end

endmodule

// File: tb/tb_packet_frame_arbiter.sv
// Directed bench for packet_frame_arbiter: vector table plus timeout and reset sequences.
module tb_packet_frame_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req, in_valid, in_head, in_tail;
    logic [3:0] grant;
    logic       out_valid, out_head, out_tail, busy, err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic [3:0] req, v, h, t;
        logic [3:0] g;
        logic       ov, oh, ot, bz, er;
    } vec_t;

    vec_t vecs[$];

    packet_frame_arbiter #(.NREQ(4), .TIMEOUT(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in_valid  (in_valid),
        .in_head   (in_head),
        .in_tail   (in_tail),
        .grant     (grant),
        .out_valid (out_valid),
        .out_head  (out_head),
        .out_tail  (out_tail),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(string n, logic [3:0] r, logic [3:0] v, logic [3:0] h,
                                logic [3:0] t, logic [3:0] g, logic ov, logic oh,
                                logic ot, logic bz, logic er);
        vec_t x;
        x.name = n; x.req = r; x.v = v; x.h = h; x.t = t;
        x.g = g; x.ov = ov; x.oh = oh; x.ot = ot; x.bz = bz; x.er = er;
        return x;
    endfunction

    task automatic check_outs(input string n, input logic [3:0] g, input logic ov,
                              input logic oh, input logic ot, input logic bz, input logic er);
        logic [8:0] act, exp;
        act = {grant, out_valid, out_head, out_tail, busy, err};
        exp = {g, ov, oh, ot, bz, er};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got grant/v/h/t/busy/err=%b expected %b", n, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] v,
                         input logic [3:0] h, input logic [3:0] t);
        req = r; in_valid = v; in_head = h; in_tail = t;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Each row: inputs for one cycle, then outputs expected after that edge.
        vecs.push_back(mk("t1_grant", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t1_head",  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1, 1, 0, 1, 0));
        vecs.push_back(mk("t1_mid1",  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1, 0));
        vecs.push_back(mk("t1_mid2",  4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1, 0));
        vecs.push_back(mk("t1_tail",  4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t1_rel",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_ptr1",  4'b0011, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t2_b1",    4'b1111, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 1, 1, 0, 0));
        vecs.push_back(mk("t2_d1",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_g2",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t2_b2",    4'b1111, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 1, 1, 0, 0));
        vecs.push_back(mk("t2_d2",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_g3",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t2_b3",    4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 1, 1, 1, 0, 0));
        vecs.push_back(mk("t2_d3",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t2_g0",    4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t2_b0",    4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0, 0));
        vecs.push_back(mk("t2_d0",    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t4_grant", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t4_head",  4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 1, 0));
        vecs.push_back(mk("t4_head2", 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 1, 1));
        vecs.push_back(mk("t4_mid",   4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 0, 0, 1, 0));
        vecs.push_back(mk("t4_tail",  4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t4_rel",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("t5_grant", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t5_head",  4'b0001, 4'b1001, 4'b1001, 4'b1000, 4'b0001, 1, 1, 0, 1, 0));
        vecs.push_back(mk("t5_only3", 4'b0001, 4'b1000, 4'b1000, 4'b1000, 4'b0001, 0, 0, 0, 1, 0));
        vecs.push_back(mk("t5_tail",  4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 1, 0, 1, 0, 0));
        vecs.push_back(mk("t5_rel",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk("nohead_g", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, 1, 0));
        vecs.push_back(mk("nohead_v", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, 1, 1));
        vecs.push_back(mk("nohead_p", 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0, 0));
        vecs.push_back(mk("nohead_r", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0));

        reset = 1'b0;
        drive(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        repeat (2) tick();
        check_outs("reset_state", 4'b0000, 0, 0, 0, 0, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].v, vecs[i].h, vecs[i].t);
            tick();
            check_outs(vecs[i].name, vecs[i].g, vecs[i].ov, vecs[i].oh, vecs[i].ot,
                       vecs[i].bz, vecs[i].er);
        end

        // Timeout: rr_ptr is 1 here, requester 1 granted and then silent.
        drive(4'b0110, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_outs("t3_grant", 4'b0010, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check_outs($sformatf("t3_wait%0d", k), 4'b0010, 0, 0, 0, 1, 0);
        end
        tick();
        check_outs("t3_timeout", 4'b0010, 0, 0, 0, 0, 1);
        tick();
        check_outs("t3_release", 4'b0000, 0, 0, 0, 0, 0);
        tick();
        check_outs("t3_next", 4'b0100, 0, 0, 0, 1, 0);

        // Reset in the middle of requester 2's packet.
        drive(4'b0110, 4'b0100, 4'b0100, 4'b0000);
        tick();
        check_outs("t6_head", 4'b0100, 1, 1, 0, 1, 0);
        reset = 1'b0;
        #2;
        check_outs("t6_async", 4'b0000, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        drive(4'b1111, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check_outs("t6_restart", 4'b0001, 0, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
